// File: rtl/edge_detector_mc.sv
// Multi-channel edge detector: synchroniser, debounce and per-channel edge-select pulse.
// Optional sticky event flags are enabled by defining EDGE_DETECTOR_MC_STICKY_EN.
module edge_detector_mc #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_CH-1:0]     sig_i,
  input  logic [2*NUM_CH-1:0]   mode_i,
  input  logic [NUM_CH-1:0]     clr_i,
  output logic [NUM_CH-1:0]     level_o,
  output logic [NUM_CH-1:0]     pulse_o,
  output logic [NUM_CH-1:0]     sticky_o,
  output logic                  irq_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = sig_i;
    end else begin : g_sync
      logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= sig_i;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] level_q, level_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;

  // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (s[c] == level_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == CNT_LAST) begin
        cnt_d[c]   = '0;
        level_d[c] = s[c];
        pulse_d[c] = s[c] ? mode_i[2*c] : mode_i[2*c+1];
      end else begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '0;
      pulse_q <= '0;
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
    end else begin
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

`ifdef EDGE_DETECTOR_MC_STICKY_EN
  logic [NUM_CH-1:0] sticky_q, sticky_d;

  // A pulse arriving with a clear keeps the flag set.
  assign sticky_d = pulse_q | (sticky_q & ~clr_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) sticky_q <= '0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_o = sticky_q;
  assign irq_o    = |sticky_q;
`else
  logic unused_clr;
  assign unused_clr = ^clr_i;
  assign sticky_o   = '0;
  assign irq_o      = |pulse_q;
`endif

endmodule

// File: tb/tb_edge_detector_mc.sv
// Randomised and directed bench for edge_detector_mc against a window-based behavioural model.
// Define EDGE_DETECTOR_MC_STICKY_EN for both bench and RTL to exercise the sticky flags.
module tb_edge_detector_mc;

  localparam int NUM_CH = 4;
  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int MAXN   = 8192;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic [NUM_CH-1:0]   sig_i = '0;
  logic [2*NUM_CH-1:0] mode_i = '0;
  logic [NUM_CH-1:0]   clr_i = '0;
  logic [NUM_CH-1:0]   level_o, pulse_o, sticky_o;
  logic                irq_o;

  edge_detector_mc #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .sig_i(sig_i), .mode_i(mode_i), .clr_i(clr_i),
    .level_o(level_o), .pulse_o(pulse_o), .sticky_o(sticky_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a channel's level flips when the synchronised input has disagreed
  // with it on each of the last DEB edges since the last flip or reset.
  logic [NUM_CH-1:0] sig_log [MAXN];
  int n = 0;
  int last_rst = -1000;
  int last_evt [NUM_CH];
  bit [NUM_CH-1:0] m_level = '0, m_pulse = '0, m_sticky = '0;
  bit m_irq;

  function automatic bit s_at(input int c, input int m);
    if (m - SYNC <= last_rst || m - SYNC < 0) return 1'b0;
    return sig_log[(m - SYNC) % MAXN][c];
  endfunction

  always @(posedge clk) begin
    bit [NUM_CH-1:0] prev_pulse;
    n++;
    sig_log[n % MAXN] = sig_i;
    prev_pulse = m_pulse;
    if (rst_i) begin
      last_rst = n;
      m_level = '0; m_pulse = '0; m_sticky = '0;
      for (int c = 0; c < NUM_CH; c++) last_evt[c] = n;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        bit flip;
        bit [1:0] md;
        flip = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (n - j <= last_evt[c] || s_at(c, n - j) == m_level[c]) flip = 1'b0;
        m_pulse[c] = 1'b0;
        if (flip) begin
          m_level[c] = ~m_level[c];
          last_evt[c] = n;
          md = mode_i[2*c +: 2];
          if (m_level[c]) m_pulse[c] = (md == 2'b01 || md == 2'b11);
          else            m_pulse[c] = (md == 2'b10 || md == 2'b11);
        end
      end
`ifdef EDGE_DETECTOR_MC_STICKY_EN
      m_sticky = prev_pulse | (m_sticky & ~clr_i);
`endif
    end
`ifdef EDGE_DETECTOR_MC_STICKY_EN
    m_irq = |m_sticky;
`else
    m_irq = |m_pulse;
`endif
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", 32'(level_o), 32'(m_level));
      chk("pulse", 32'(pulse_o), 32'(m_pulse));
      chk("sticky", 32'(sticky_o), 32'(m_sticky));
      chk("irq", 32'(irq_o), 32'(m_irq));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (12) step();
  endtask

  initial begin
    logic [NUM_CH-1:0] acc;
    int cnt1;

    repeat (3) step();
    chk("rst_level", 32'(level_o), 32'h0);
    chk("rst_pulse", 32'(pulse_o), 32'h0);
    chk("rst_sticky", 32'(sticky_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk_en = 1'b1;
    rst_i = 1'b0;
    settle();

    // Basic rising edge on ch0: pulse visible after the 6th edge (5 after the first sampling edge).
    mode_i = 8'b00_00_00_01;
    sig_i  = 4'b0001;
    repeat (5) step();
    chk("basic_pulse_early", 32'(pulse_o[0]), 32'h0);
    chk("basic_level_early", 32'(level_o[0]), 32'h0);
    step();
    chk("basic_pulse", 32'(pulse_o[0]), 32'h1);
    chk("basic_level", 32'(level_o[0]), 32'h1);
    chk("basic_irq", 32'(irq_o), 32'h1);
    chk("basic_model_pulse", 32'(m_pulse[0]), 32'h1);
    step();
    chk("basic_pulse_width", 32'(pulse_o[0]), 32'h0);
    chk("basic_level_hold", 32'(level_o[0]), 32'h1);
    sig_i = '0;
    settle();

    // Glitch rejection on ch1: 3 cycles high rejected, 4 cycles accepted.
    mode_i = 8'b00_00_01_00;
    sig_i = 4'b0010;
    repeat (3) step();
    sig_i = '0;
    cnt1 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (pulse_o[1]) cnt1++;
      chk("glitch_level", 32'(level_o[1]), 32'h0);
    end
    chk("glitch_pulses", 32'(cnt1), 32'h0);
    sig_i = 4'b0010;
    repeat (4) step();
    sig_i = '0;
    cnt1 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (pulse_o[1]) cnt1++;
    end
    chk("accept_pulses", 32'(cnt1), 32'h1);
    settle();

    // Mode coverage: ch0..3 = off, rising, falling, both.
    mode_i = 8'b11_10_01_00;
    sig_i = 4'b1111;
    acc = '0;
    for (int i = 0; i < 10; i++) begin step(); acc |= pulse_o; end
    chk("mode_rise", 32'(acc), 32'hA);
    chk("mode_level_hi", 32'(level_o), 32'hF);
    sig_i = 4'b0000;
    acc = '0;
    for (int i = 0; i < 10; i++) begin step(); acc |= pulse_o; end
    chk("mode_fall", 32'(acc), 32'hC);
    chk("mode_level_lo", 32'(level_o), 32'h0);
    settle();

    // Reset mid-debounce with input held high.
    mode_i = 8'b00_00_00_01;
    sig_i = 4'b0001;
    repeat (4) step();
    rst_i = 1'b1;
    repeat (2) begin
      step();
      chk("rstmid_level", 32'(level_o), 32'h0);
      chk("rstmid_pulse", 32'(pulse_o), 32'h0);
      chk("rstmid_irq", 32'(irq_o), 32'h0);
    end
    rst_i = 1'b0;
    repeat (5) step();
    chk("rstrel_pulse_early", 32'(pulse_o[0]), 32'h0);
    step();
    chk("rstrel_pulse", 32'(pulse_o[0]), 32'h1);
    sig_i = '0;
    settle();

`ifdef EDGE_DETECTOR_MC_STICKY_EN
    mode_i = 8'b00_01_00_00;
    sig_i = 4'b0100;
    repeat (6) step();
    chk("sticky_pulse", 32'(pulse_o), 32'h4);
    step();
    chk("sticky_set", 32'(sticky_o), 32'h4);
    chk("sticky_irq", 32'(irq_o), 32'h1);
    sig_i = '0;
    settle();
    sig_i = 4'b0100;
    repeat (6) step();
    clr_i = 4'b0100;
    step();
    clr_i = '0;
    chk("sticky_setwins", 32'(sticky_o), 32'h4);
    sig_i = '0;
    settle();
    clr_i = 4'b0100;
    step();
    clr_i = '0;
    chk("sticky_clr", 32'(sticky_o), 32'h0);
    chk("sticky_clr_irq", 32'(irq_o), 32'h0);
    settle();
`endif

    // Randomised traffic with mode changes, clears and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 4) == 0) sig_i[c] = ~sig_i[c];
      if (i % 64 == 0) mode_i = 8'($urandom);
      clr_i = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      rst_i = ($urandom_range(0, 299) == 0);
      step();
    end
    rst_i = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
